// File: rtl/cache_pkg.sv
// cache_pkg: constants, types and helpers shared by the cache line adapter.
//   S_OFFSET/S_WORD/S_LINE/N_BEATS : line geometry (32-byte line, 32-bit word)
//   CNT_W                          : beat counter width, holds 0..N_BEATS
//   line_t, word_t                 : line and memory word containers
//   adapter_state_t                : adapter FSM states
package cache_pkg;
  localparam int S_OFFSET = 5;
  localparam int S_WORD   = 32;
  localparam int S_LINE   = 256;
  localparam int N_BEATS  = S_LINE / S_WORD;
  localparam int CNT_W    = $clog2(N_BEATS) + 1;

  typedef logic [S_LINE-1:0] line_t;
  typedef logic [S_WORD-1:0] word_t;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} adapter_state_t;
endpackage

// File: rtl/cache_line_adapter_if.sv
// cache_line_adapter_if: word-wide main-memory port of the line adapter.
//   master (adapter) : drives mem_req/mem_we/mem_addr/mem_wdata,
//                      receives mem_gnt/mem_rvalid/mem_rdata
//   slave  (memory)  : the mirror image
// A beat is accepted in a cycle where mem_req and mem_gnt are both high.
// Read data returns in order on mem_rvalid, at least one cycle after grant.
interface cache_line_adapter_if;
  import cache_pkg::*;

  logic  mem_req;
  logic  mem_we;
  word_t mem_addr;
  word_t mem_wdata;
  logic  mem_gnt;
  logic  mem_rvalid;
  word_t mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cache_beat_counter.sv
// cache_beat_counter: saturating 0..N counter.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear, wins over inc
//   inc      : count up by one unless already at N
//   cnt      : current count
//   full     : cnt == N
module cache_beat_counter #(
  parameter int N = 8,
  parameter int W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         full
);
  logic [W-1:0] cnt_q, cnt_d;

  assign cnt  = cnt_q;
  assign full = (cnt_q == W'(N));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)              cnt_d = '0;
    else if (inc && !full) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cache_line_adapter.sv
// cache_line_adapter: moves 256-bit lines between the cache datapath and a
// 32-bit main-memory port.
//   clk, rst            : clock, asynchronous active-low reset
//   wb_req/wb_addr/wb_line : write a dirty line back as 8 word writes
//   fill_req/fill_addr  : read a line as 8 word reads into fill_line
//   busy                : high whenever the FSM is out of IDLE
//   done                : single-cycle pulse when the whole request finishes
//   fill_line           : assembled fill data (feeds the datapath dataIn)
//   mem                 : memory port (master side)
// A combined wb_req+fill_req runs the writeback first, then the fill.
module cache_line_adapter
  import cache_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_line   = S_LINE,
  parameter int s_word   = S_WORD,
  parameter int n_beats  = s_line / s_word
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_req,
  input  logic                 fill_req,
  input  logic [31:0]          wb_addr,
  input  logic [31:0]          fill_addr,
  input  logic [s_line-1:0]    wb_line,
  output logic                 busy,
  output logic                 done,
  output logic [s_line-1:0]    fill_line,
  cache_line_adapter_if.master mem
);
  localparam int CW = $clog2(n_beats) + 1;

  adapter_state_t          state_q, state_d;
  logic                    fill_pending_q, fill_pending_d;
  logic [31:s_offset]      wb_base_q, wb_base_d;
  logic [31:s_offset]      fill_base_q, fill_base_d;
  logic [s_line-1:0]       wb_line_q, wb_line_d;
  logic [s_line-1:0]       fill_line_q, fill_line_d;

  // iss counts write beats in WB and read issues in FILL; rsp counts read data.
  logic          iss_clr, iss_inc, iss_full;
  logic          rsp_clr, rsp_inc, rsp_full_unused;
  logic [CW-1:0] iss_cnt, rsp_cnt;

  // Line-offset bits of the request addresses carry no information here.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{wb_addr[s_offset-1:0], fill_addr[s_offset-1:0]};

  cache_beat_counter #(.N(n_beats), .W(CW)) u_iss (
    .clk  (clk),
    .rst  (rst),
    .clr  (iss_clr),
    .inc  (iss_inc),
    .cnt  (iss_cnt),
    .full (iss_full)
  );

  cache_beat_counter #(.N(n_beats), .W(CW)) u_rsp (
    .clk  (clk),
    .rst  (rst),
    .clr  (rsp_clr),
    .inc  (rsp_inc),
    .cnt  (rsp_cnt),
    .full (rsp_full_unused)
  );

  assign fill_line = fill_line_q;

  always_comb begin
    state_d        = state_q;
    fill_pending_d = fill_pending_q;
    wb_base_d      = wb_base_q;
    fill_base_d    = fill_base_q;
    wb_line_d      = wb_line_q;
    fill_line_d    = fill_line_q;
    iss_clr        = 1'b0;
    iss_inc        = 1'b0;
    rsp_clr        = 1'b0;
    rsp_inc        = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;

    unique case (state_q)
      IDLE: begin
        busy    = 1'b0;
        iss_clr = 1'b1;
        rsp_clr = 1'b1;
        if (wb_req || fill_req) begin
          wb_base_d      = wb_addr[31:s_offset];
          fill_base_d    = fill_addr[31:s_offset];
          wb_line_d      = wb_line;
          fill_pending_d = fill_req;
          if (wb_req) begin
            state_d = WB;
          end else begin
            state_d     = FILL;
            fill_line_d = '0;
          end
        end
      end

      WB: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {wb_base_q, iss_cnt[CW-2:0], 2'b00};
        mem.mem_wdata = wb_line_q[s_word*iss_cnt[CW-2:0] +: s_word];
        iss_inc       = mem.mem_gnt;
        if (mem.mem_gnt && iss_cnt == CW'(n_beats - 1)) begin
          // Reuse the issue counter for the fill's read beats.
          iss_clr = 1'b1;
          if (fill_pending_q) begin
            state_d     = FILL;
            fill_line_d = '0;
          end else begin
            state_d = DONE;
          end
        end
      end

      FILL: begin
        mem.mem_req = !iss_full;
        if (!iss_full) mem.mem_addr = {fill_base_q, iss_cnt[CW-2:0], 2'b00};
        iss_inc = !iss_full && mem.mem_gnt;
        // Only data for an already-granted read is accepted.
        if (mem.mem_rvalid && (rsp_cnt < iss_cnt)) begin
          rsp_inc = 1'b1;
          fill_line_d[s_word*rsp_cnt[CW-2:0] +: s_word] = mem.mem_rdata;
          if (rsp_cnt == CW'(n_beats - 1)) state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      fill_pending_q <= 1'b0;
      wb_base_q      <= '0;
      fill_base_q    <= '0;
      wb_line_q      <= '0;
      fill_line_q    <= '0;
    end else begin
      state_q        <= state_d;
      fill_pending_q <= fill_pending_d;
      wb_base_q      <= wb_base_d;
      fill_base_q    <= fill_base_d;
      wb_line_q      <= wb_line_d;
      fill_line_q    <= fill_line_d;
    end
  end
endmodule

// File: tb/tb_cache_line_adapter.sv
// tb_cache_line_adapter: table-driven transactions against a small memory
// model. Expected write beats / read addresses are queued when a request is
// driven and popped as the DUT presents granted beats; done timing and the
// assembled line are compared per vector. Hand sequences cover stray rvalid,
// requests while busy, and reset in the middle of a fill.
module tb_cache_line_adapter;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_req = 1'b0, fill_req = 1'b0;
  logic [31:0] wb_addr = '0, fill_addr = '0;
  line_t       wb_line = '0;
  logic        busy, done;
  line_t       fill_line;

  always #5 clk = ~clk;

  cache_line_adapter_if mif();

  cache_line_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .wb_req    (wb_req),
    .fill_req  (fill_req),
    .wb_addr   (wb_addr),
    .fill_addr (fill_addr),
    .wb_line   (wb_line),
    .busy      (busy),
    .done      (done),
    .fill_line (fill_line),
    .mem       (mif)
  );

  typedef struct {
    logic        wb;
    logic        fill;
    logic [31:0] wb_addr;
    logic [31:0] fill_addr;
    logic [31:0] wbase;      // write word k = wbase + k
    logic [31:0] rbase;      // read data of beat k = rbase + k
    int          stall_beat; // beat index to hold off (-1 none)
    logic        stall_we;   // stall applies to write (1) or read (0) beats
    int          stall_len;
    int          exp_done;   // cycle of done, request sampled at edge 0
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  vec_t        vecs[6];
  beat_t       wr_q[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad   = 0;

  // memory model controls
  int          stall_beat = -1;
  logic        stall_we   = 1'b0;
  int          stall_left = 0;
  logic [31:0] rbase      = '0;
  logic        stray_rv   = 1'b0;
  logic        pend       = 1'b0;
  logic [31:0] pend_data  = '0;
  logic        holding    = 1'b0;
  logic [31:0] hold_addr  = '0, hold_wdata = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic line_t mk_line(input logic [31:0] base);
    line_t l;
    for (int k = 0; k < N_BEATS; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  // Memory: decides gnt for the coming edge, checks accepted beats against
  // the scoreboard, returns read data one cycle after grant.
  initial begin
    mif.mem_gnt    = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = '0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      mif.mem_gnt    = 1'b0;
      mif.mem_rvalid = 1'b0;
      pend           = 1'b0;
      holding        = 1'b0;
    end else begin
      mif.mem_rvalid = pend | stray_rv;
      mif.mem_rdata  = pend ? pend_data : 32'hDEAD_BEEF;
      pend           = 1'b0;
      mif.mem_gnt    = 1'b1;
      if (mif.mem_req) begin
        if (holding) begin
          chk("hold_addr",  mif.mem_addr,  hold_addr);
          chk("hold_wdata", mif.mem_wdata, hold_wdata);
        end
        if (stall_left > 0 && int'(mif.mem_addr[4:2]) == stall_beat &&
            mif.mem_we == stall_we) begin
          mif.mem_gnt = 1'b0;
          stall_left--;
          holding    = 1'b1;
          hold_addr  = mif.mem_addr;
          hold_wdata = mif.mem_wdata;
        end else begin
          holding = 1'b0;
          if (mif.mem_we) begin
            chk("wr_expected", 256'(wr_q.size() != 0), 256'd1);
            if (wr_q.size() != 0) begin
              beat_t b;
              b = wr_q.pop_front();
              chk("wr_addr",  mif.mem_addr,  b.addr);
              chk("wr_wdata", mif.mem_wdata, b.data);
            end
          end else begin
            chk("rd_expected", 256'(rd_q.size() != 0), 256'd1);
            if (rd_q.size() != 0) chk("rd_addr", mif.mem_addr, rd_q.pop_front());
            pend      = 1'b1;
            pend_data = rbase + 32'(mif.mem_addr[4:2]);
          end
        end
      end
    end
  end

  // Called just after a negedge: drives the request for edge 0 and returns
  // at the negedge of cycle 1 with the inputs scrambled.
  task automatic start(input vec_t v);
    stall_beat = v.stall_beat;
    stall_we   = v.stall_we;
    stall_left = v.stall_len;
    rbase      = v.rbase;
    wb_req     = v.wb;
    fill_req   = v.fill;
    wb_addr    = v.wb_addr;
    fill_addr  = v.fill_addr;
    wb_line    = mk_line(v.wbase);
    if (v.wb)
      for (int k = 0; k < N_BEATS; k++)
        wr_q.push_back('{addr: {v.wb_addr[31:5], 5'b0} + 32'(4*k), data: v.wbase + 32'(k)});
    if (v.fill)
      for (int k = 0; k < N_BEATS; k++)
        rd_q.push_back({v.fill_addr[31:5], 5'b0} + 32'(4*k));
    @(negedge clk);
    wb_req    = 1'b0;
    fill_req  = 1'b0;
    wb_addr   = 32'hFFFF_FFE0;
    fill_addr = 32'hFFFF_FFE0;
    wb_line   = '1;
  endtask

  task automatic finish_txn(input vec_t v, input string tag, input int cyc0);
    int cyc;
    bit seen;
    cyc  = cyc0;
    seen = 0;
    while (cyc < 60 && !seen) begin
      if (done) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_done_cycle"}, 256'(cyc), 256'(v.exp_done));
    chk({tag, "_busy_at_done"}, 256'(busy), 256'd1);
    if (v.fill) chk({tag, "_fill_line"}, fill_line, mk_line(v.rbase));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 256'(done), 256'd0);
    chk({tag, "_idle_busy"}, 256'(busy), 256'd0);
    chk({tag, "_sb_empty"}, 256'(wr_q.size() + rd_q.size()), 256'd0);
  endtask

  task automatic run(input vec_t v, input string tag);
    start(v);
    chk({tag, "_busy_c1"}, 256'(busy), 256'd1);
    finish_txn(v, tag, 1);
  endtask

  initial begin
    vec_t v;
    //         wb    fill  wb_addr        fill_addr      wbase  rbase   sbeat sw    slen done
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1240, 32'h0,         32'hA0, 32'h0,   -1, 1'b1, 0,   9};
    vecs[1] = '{1'b0, 1'b1, 32'h0,         32'h0000_0080, 32'h0,  32'h100, -1, 1'b0, 0,  10};
    vecs[2] = '{1'b1, 1'b1, 32'h2000_0040, 32'h3000_1F9F, 32'hB0, 32'h200, -1, 1'b0, 0,  18};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_ABDF, 32'h0,         32'hC0, 32'h0,    2, 1'b1, 3,  12};
    vecs[4] = '{1'b0, 1'b1, 32'h0,         32'h0000_0FE0, 32'h0,  32'h700,  5, 1'b0, 2,  12};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_4000, 32'h0000_5000, 32'hD0, 32'h900,  0, 1'b0, 1,  19};

    repeat (2) @(negedge clk);
    chk("rst_busy",      256'(busy),         256'd0);
    chk("rst_done",      256'(done),         256'd0);
    chk("rst_mem_req",   256'(mif.mem_req),  256'd0);
    chk("rst_fill_line", fill_line,          256'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Stray rvalid while idle: nothing may change.
    stray_rv = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_done", 256'(done), 256'd0);
      chk("stray_busy", 256'(busy), 256'd0);
    end
    stray_rv = 1'b0;
    @(negedge clk);
    chk("stray_fill_line", fill_line, mk_line(vecs[5].rbase));
    chk("stray_mem_req", 256'(mif.mem_req), 256'd0);

    // New requests while busy are ignored (no writes, one done).
    v = '{1'b0, 1'b1, 32'h0, 32'h0000_0500, 32'h0, 32'h300, -1, 1'b0, 0, 10};
    start(v);
    @(negedge clk);
    wb_req   = 1'b1;
    fill_req = 1'b1;
    wb_addr  = 32'h0000_9000;
    repeat (2) @(negedge clk);
    wb_req   = 1'b0;
    fill_req = 1'b0;
    finish_txn(v, "busy_ign", 4);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 11) begin
        chk("busy_ign_no_done", 256'(done), 256'd0);
        chk("busy_ign_idle",    256'(busy), 256'd0);
      end else if (done) begin
        chk("busy_ign_extra_done", 256'(done), 256'd0);
      end
    end

    // Reset during read beat 4 of a fill.
    v = '{1'b0, 1'b1, 32'h0, 32'h0000_0400, 32'h0, 32'h400, -1, 1'b0, 0, 10};
    start(v);
    repeat (4) @(negedge clk);
    chk("abort_beat4_addr", mif.mem_addr, 32'h0000_0410);
    chk("abort_beat4_req",  256'(mif.mem_req), 256'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy",      256'(busy),        256'd0);
    chk("abort_done",      256'(done),        256'd0);
    chk("abort_mem_req",   256'(mif.mem_req), 256'd0);
    chk("abort_mem_addr",  mif.mem_addr,      32'd0);
    chk("abort_fill_line", fill_line,         256'd0);
    wr_q.delete();
    rd_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 256'(done), 256'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle_after", 256'(busy), 256'd0);
    v = '{1'b0, 1'b1, 32'h0, 32'h0000_0600, 32'h0, 32'h600, -1, 1'b0, 0, 10};
    run(v, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_line_adapter.md
# cache_line_adapter

Memory-side line transfer unit for the 2-way cache: it moves whole 256-bit lines between the cache datapath and a 32-bit word-wide main-memory port. It serves three request types, all issued by the cache controller:
- **Writeback:** an evicted dirty line is split into 8 word writes.
- **Fill:** a missed line is assembled from 8 word reads.
- **Writeback-then-fill:** a dirty miss issues both requests together; the writeback runs first.

The block sits directly downstream of the cache datapath. Its `fill_line` output feeds the datapath's `dataIn`.

## Interface
Parameters:
- `s_offset`, 5, byte-offset bits of a line (32-byte line).
- `s_line`, 256, line width in bits.
- `s_word`, 32, memory word width in bits.
- `n_beats`, `s_line/s_word` = 8, words per line.

Ports (`clk` is the single clock; `rst` is asynchronous and active-low):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-low reset
- `wb_req`  in  1  start writeback of `wb_line` to `wb_addr`
- `fill_req`  in  1  start fill from `fill_addr`
- `wb_addr`  in  32  writeback line address; bits [4:0] ignored
- `fill_addr`  in  32  fill line address; bits [4:0] ignored
- `wb_line`  in  256  line data to write back
- `busy`  out  1  transfer in progress (state ≠ IDLE)
- `done`  out  1  one-cycle pulse when the whole request completes
- `fill_line`  out  256  assembled fill data; valid from `done` until the next fill starts
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  1 = write beat, 0 = read beat
- `mem_addr`  out  32  word address of the beat
- `mem_wdata`  out  32  write data
- `mem_gnt`  in  1  memory accepts the current beat this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read data

## Operation
**States:** IDLE, WB, FILL, DONE.

**IDLE**
- Requests are sampled only in IDLE. While `busy` is high, `wb_req` and `fill_req` are ignored.
- On a request, the block latches `wb_addr`, `fill_addr`, `wb_line` and a `fill_pending` flag.
- Transitions: `wb_req` → WB (regardless of `fill_req`); `fill_req` only → FILL.

**WB**
- `mem_req`=1, `mem_we`=1.
- `mem_addr` = {wb_addr[31:5], beat[2:0], 2'b00}.
- `mem_wdata` = latched line[32·beat +: 32]. Beat 0 is bits [31:0].
- The beat advances on `mem_gnt`.
- On the 8th grant: go to FILL if `fill_pending`, else DONE.

**FILL**
- Issue counter `iss` (0–8) drives read beats: `mem_req`=1 while iss<8, `mem_we`=0, `mem_addr` = {fill_addr[31:5], iss[2:0], 2'b00}.
- `iss` increments on `mem_gnt`.
- Response counter `rsp` (0–8): each `mem_rvalid` while rsp<iss writes `mem_rdata` into `fill_line[32·rsp +: 32]`, then `rsp` increments.
- Responses arrive in order, no earlier than the cycle after their grant.
- Issue and response run concurrently.
- When `rsp` reaches 8 → DONE.

**DONE**
- `done`=1 for exactly one cycle, then → IDLE.

**Handshake and boundary rules:**
- `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req`=1 and `mem_gnt`=0.
- `mem_req` is 0 in IDLE, in DONE, and in FILL once iss=8.
- A `mem_rvalid` with no outstanding read (rsp=iss) is ignored and writes nothing.
- Counters are `$clog2(n_beats)+1` bits wide. Beat index wrap never occurs; each counter stops at 8.
- `fill_line` is cleared to 0 when a fill starts.

**Reset:** asynchronous and active-low, at any time including mid-transfer.
- State returns to IDLE and all counters clear.
- All outputs go to 0, including `fill_line`.
- No `done` is produced for the aborted transfer.

## Timing
- Requests are sampled at edge 0. The first beat is presented in cycle 1; there is no combinational path from request to `mem_req`.
- Writeback, `mem_gnt` held high: beats in cycles 1–8, `done` in cycle 9.
- Fill, `mem_gnt` high and 1-cycle read latency: issues in cycles 1–8, `rvalid` in cycles 2–9, `done` in cycle 10.
- Writeback-then-fill: WB in cycles 1–8, FILL issues in cycles 9–16, `done` in cycle 18.
- Each cycle of `mem_gnt`=0 extends the transfer by one cycle.
- `busy` is high from cycle 1 through the DONE cycle inclusive.

## Structure
- Shared package `cache_pkg` holds:
  - `N_BEATS`, `S_WORD`, `S_LINE` constants;
  - `line_t` (logic [255:0]);
  - `adapter_state_t` enum {IDLE, WB, FILL, DONE}.
- Sub-module `cache_beat_counter`: a saturating 0..N counter with clear, increment and `full` flag. It is instantiated twice, once for the WB/issue beat and once for the response count.

## Test plan
- Writeback, gnt=1: `wb_req`, wb_addr=0x0000_1240, line words 0..7 = 0xA0..0xA7 → 8 writes to 0x1240, 0x1244, …, 0x125C with wdata 0xA0..0xA7; `done` in cycle 9.
- Fill, 1-cycle latency: `fill_req`, fill_addr=0x0000_0080, rdata = 0x100+beat → `fill_line` word k = 0x100+k; `done` in cycle 10.
- Dirty miss: `wb_req` and `fill_req` in the same cycle → all 8 writes precede the first read, `done` pulses once, in cycle 18.
- Backpressure: `mem_gnt` low for 3 cycles on beat 2 → `mem_addr` and `mem_wdata` held stable, total latency +3, data unchanged.
- Stray `rvalid` in IDLE, and a new `fill_req` while busy → both ignored, no extra `done`.
- `rst` asserted during fill beat 4 → outputs 0 and state IDLE immediately, no `done`; a subsequent fill completes correctly.
